fetch_aligner: RTL

Instruction-fetch realignment stage that sits directly upstream of the decode and control logic in the RV32IC core. It fetches word-aligned 32-bit words from instruction memory, buffers them as halfwords, and presents one complete instruction per cycle: either 16-bit compressed or 32-bit, at any halfword-aligned PC. Its `instr_o[6:0]` is the opcode source for decode after decompression. It also handles control-flow redirects from JAL, JALR and taken branches.

---
 rtl/fetch_aligner_if.sv | 27 ++
 rtl/fetch_aligner.sv | 103 ++++++++++
 2 files changed

// File: rtl/fetch_aligner_if.sv
// Fetch aligner bus: word fetch port toward instruction memory, redirect and
// stall from the core, and the aligned instruction toward decode.
interface fetch_aligner_if;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_valid_i;
  logic [31:0] mem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        stall_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic        instr_is_c_o;
  logic [31:0] instr_pc_o;

  // Aligner side
  modport master (
    output mem_req_o, mem_addr_o, instr_valid_o, instr_o, instr_is_c_o, instr_pc_o,
    input  mem_valid_i, mem_rdata_i, redirect_i, redirect_pc_i, stall_i
  );

  // Memory / core side
  modport slave (
    input  mem_req_o, mem_addr_o, instr_valid_o, instr_o, instr_is_c_o, instr_pc_o,
    output mem_valid_i, mem_rdata_i, redirect_i, redirect_pc_i, stall_i
  );
endinterface

// File: rtl/fetch_aligner.sv
// Instruction-fetch realignment: word fetches go into a halfword FIFO, and one
// compressed or 32-bit instruction is presented per cycle from its head.
module fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          HW_DEPTH = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  fetch_aligner_if.master bus
);
  localparam int CW = $clog2(HW_DEPTH + 1);
  typedef logic [CW-1:0] cnt_t;

  logic [15:0] hw_buf [HW_DEPTH];
  logic [15:0] hw_nxt [HW_DEPTH];
  logic [15:0] hw_ext [HW_DEPTH+2];
  cnt_t        count, count_nxt, base;
  logic [31:0] fetch_addr, pc;
  logic        outstanding, discard, drop_low;
  logic [15:0] hw0, hw1, push_lo;
  logic        is_c, vld, consume, resp, req;
  logic [1:0]  pop_n, push_n;

  assign hw0  = hw_buf[0];
  assign hw1  = hw_buf[1];
  assign is_c = (hw0[1:0] != 2'b11);

  // A redirect hides whatever is in the buffer: it belongs to the old path.
  assign vld = !rst_i && !bus.redirect_i &&
               (is_c ? (count != '0) : (count >= cnt_t'(2)));
  // Only one word in flight, and only when both of its halfwords fit.
  assign req = !rst_i && !outstanding && !bus.redirect_i &&
               ((cnt_t'(HW_DEPTH) - count) >= cnt_t'(2));

  assign consume = vld && !bus.stall_i;
  assign resp    = bus.mem_valid_i && outstanding;
  assign pop_n   = consume ? (is_c ? 2'd1 : 2'd2) : 2'd0;
  assign push_n  = (resp && !discard) ? (drop_low ? 2'd1 : 2'd2) : 2'd0;
  assign push_lo = drop_low ? bus.mem_rdata_i[31:16] : bus.mem_rdata_i[15:0];
  assign base    = count - cnt_t'(pop_n);
  assign count_nxt = count + cnt_t'(push_n) - cnt_t'(pop_n);

  assign bus.mem_req_o     = req;
  assign bus.mem_addr_o    = fetch_addr;
  assign bus.instr_valid_o = vld;
  assign bus.instr_is_c_o  = is_c;
  assign bus.instr_o       = is_c ? {16'h0, hw0} : {hw1, hw0};
  assign bus.instr_pc_o    = pc;

  // Next buffer image: shift out consumed halfwords, then append the response
  // behind the survivors (push and pop may happen together).
  always_comb begin
    for (int i = 0; i < HW_DEPTH; i++) hw_ext[i] = hw_buf[i];
    hw_ext[HW_DEPTH]   = 16'h0;
    hw_ext[HW_DEPTH+1] = 16'h0;
    for (int i = 0; i < HW_DEPTH; i++) begin
      case (pop_n)
        2'd1:    hw_nxt[i] = hw_ext[i+1];
        2'd2:    hw_nxt[i] = hw_ext[i+2];
        default: hw_nxt[i] = hw_buf[i];
      endcase
      if (push_n != 2'd0 && cnt_t'(i) == base)
        hw_nxt[i] = push_lo;
      if (push_n == 2'd2 && cnt_t'(i) == base + cnt_t'(1))
        hw_nxt[i] = bus.mem_rdata_i[31:16];
    end
  end

  // Fetch/PC state; a redirect overrides push, pop and request in its cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hw_buf      <= '{default: '0};
      count       <= '0;
      outstanding <= 1'b0;
      discard     <= 1'b0;
      fetch_addr  <= RESET_PC & ~32'h3;
      pc          <= RESET_PC;
      drop_low    <= RESET_PC[1];
    end else if (bus.redirect_i) begin
      hw_buf      <= hw_nxt;
      count       <= '0;
      pc          <= bus.redirect_pc_i & ~32'h1;
      fetch_addr  <= bus.redirect_pc_i & ~32'h3;
      drop_low    <= bus.redirect_pc_i[1];
      // A response landing this cycle is simply dropped; one still in flight
      // must be discarded when it eventually arrives.
      outstanding <= outstanding && !bus.mem_valid_i;
      discard     <= outstanding && !bus.mem_valid_i;
    end else begin
      hw_buf <= hw_nxt;
      count  <= count_nxt;
      if (req) begin
        outstanding <= 1'b1;
        fetch_addr  <= fetch_addr + 32'd4;
      end else if (resp) begin
        outstanding <= 1'b0;
      end
      if (resp && discard)              discard  <= 1'b0;
      if (resp && !discard && drop_low) drop_low <= 1'b0;
      if (consume) pc <= pc + (is_c ? 32'd2 : 32'd4);
    end
  end
endmodule
